inst_input_queue: RTL and testbench
===================================

# inst_input_queue

Parametrised instruction input stage between the machine's global instruction inputs and the decode stage. Captures each valid instruction (`instv` with `opcode`, `imm`, `src1`, `src2`, `dst`) into a circular FIFO of configurable depth. Presents instructions to decode with a valid/ready handshake and supports a pipeline flush. Flags instructions lost to overflow, so the stimulus source never needs a stall path.

## Interface
Parameters:
- `DEPTH`, 4: number of queue entries; power of two, ≥2.
- `OPCODE_W`, width of `t_opcode`: opcode field width.
- `DATA_W`, width of `t_data`: immediate field width.
- `REG_W`, width of `t_reg_name`: register-name field width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `instv` in 1: incoming instruction valid.
- `opcode` in OPCODE_W: incoming opcode.
- `imm` in DATA_W: incoming immediate.
- `src1`, `src2`, `dst` in REG_W each: incoming register names.
- `flush` in 1: discard all stored entries.
- `out_ready` in 1: decode accepts the head entry this cycle.
- `out_valid` out 1: head entry is valid.
- `out_inst` out t_inst: head instruction (all five fields).
- `in_ready` out 1: space is available, equal to `!full`.
- `full` out 1: count == DEPTH.
- `count` out $clog2(DEPTH+1): number of stored entries.
- `overflow` out 1: sticky flag, set when an instruction is dropped.

## Operation
- Push: `instv && !full` writes the instruction at `wr_ptr`; `wr_ptr` increments modulo DEPTH.
- Pop: `out_valid && out_ready` advances `rd_ptr` modulo DEPTH.
- Pointer wrap-around is natural, because DEPTH is a power of two.
- `count` increments on push only, decrements on pop only, and is unchanged when both occur.
- Full rule: `in_ready` reflects the start-of-cycle state. `instv` while full is dropped even if a pop happens in the same cycle. The drop sets `overflow`, which holds until reset.
- Flush: clears `count` and sets `rd_ptr` = `wr_ptr`. A same-cycle `instv` is still enqueued into the now-empty queue, because it is the first post-flush instruction. A same-cycle pop is ignored.
- `out_inst` is the entry at `rd_ptr`, read combinationally from storage. `out_valid` = (count != 0).
- Pop when empty: ignored, no underflow. Decode must not rely on `out_inst` while `out_valid` = 0.

## Timing
- All outputs reset to 0, except `in_ready` = 1. Pointers, count and storage all reset to 0.
- Latency without bypass: an instruction pushed at edge N is visible on `out_valid`/`out_inst` after edge N, so it can be popped at edge N+1.
- Sustained throughput is 1 instruction per cycle, provided `out_ready` is held high.
- Reset asserted mid-operation empties the queue immediately, asynchronously. It also clears `overflow`.
- The first push is accepted on the first rising edge after reset deassertion.

## Configuration
- Macro: `INPUT_QUEUE_BYPASS_EN`.
- Defined: when the queue is empty and `instv` is high, the incoming instruction appears combinationally on `out_inst` with `out_valid` = 1. If `out_ready` is also high, it is consumed without being written, and `count` stays 0. This gives zero-cycle latency.
- Defined, with `flush` in the same cycle: no bypass.
- Not defined: the bypass path is absent, and minimum latency is 1 cycle.

## Structure
- Shared package `inst_input_pkg` contains:
  - typedef struct `t_inst` {opcode, imm, src1, src2, dst};
  - the existing `t_opcode`, `t_data` and `t_reg_name`;
  - constant `INPUT_QUEUE_DEPTH_DEFAULT` = 4.
- Sub-module `inst_queue_mem`: DEPTH×t_inst register array with a write port and an asynchronous read port.
- Pointers, count, flags and bypass logic live in the top.

## Test plan
- Reset, then push 3 instructions (opcodes 1, 2, 3) with `out_ready` = 0 → `count` = 3, `out_opcode` = 1, `full` = 0.
- Fill to 4, then push opcode 9 with `out_ready` = 1 in the same cycle → opcode 9 is dropped, `overflow` = 1, `count` = 3 after the edge.
- Push 10 instructions with `out_ready` held at 1 → sequence is delivered in order, the pointers wrap twice, and `count` ≤ 1 throughout.
- `count` = 3, then `flush` together with `instv` (opcode 7) → `count` = 1 and the head opcode is 7.
- Assert `reset` mid-stream with `count` = 2 and `overflow` = 1 → all outputs return to their reset values in the same cycle.
- With `INPUT_QUEUE_BYPASS_EN`: empty queue, `instv` (opcode 5) and `out_ready` = 1 → `out_valid` = 1 and `out_opcode` = 5 in the same cycle, with `count` remaining 0.

Source files
------------

// File: rtl/inst_input_pkg.sv
// rtl/inst_input_pkg.sv - shared instruction types and default queue depth for the input stage
package inst_input_pkg;

  typedef logic [7:0]  t_opcode;
  typedef logic [15:0] t_data;
  typedef logic [4:0]  t_reg_name;

  typedef struct packed {
    t_opcode   opcode;
    t_data     imm;
    t_reg_name src1;
    t_reg_name src2;
    t_reg_name dst;
  } t_inst;

  localparam int INPUT_QUEUE_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/inst_queue_mem.sv
// rtl/inst_queue_mem.sv - DEPTH x t_inst register array, one write port, asynchronous read port
module inst_queue_mem
  import inst_input_pkg::*;
#(
  parameter int DEPTH = INPUT_QUEUE_DEPTH_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  t_inst                    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output t_inst                    rdata
);

  t_inst mem_q [DEPTH];
  t_inst mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_input_queue.sv
// rtl/inst_input_queue.sv - circular instruction FIFO feeding decode with flush and sticky overflow
// Optional zero-latency empty-queue bypass enabled by defining INPUT_QUEUE_BYPASS_EN.
module inst_input_queue
  import inst_input_pkg::*;
#(
  parameter int DEPTH    = INPUT_QUEUE_DEPTH_DEFAULT,
  parameter int OPCODE_W = $bits(t_opcode),
  parameter int DATA_W   = $bits(t_data),
  parameter int REG_W    = $bits(t_reg_name)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       instv,
  input  logic [OPCODE_W-1:0]        opcode,
  input  logic [DATA_W-1:0]          imm,
  input  logic [REG_W-1:0]           src1,
  input  logic [REG_W-1:0]           src2,
  input  logic [REG_W-1:0]           dst,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output t_inst                      out_inst,
  output logic                       in_ready,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             empty, bypass, push, pop;
  t_inst            in_inst, rd_data;

  always_comb begin
    in_inst        = '0;
    in_inst.opcode = opcode;
    in_inst.imm    = imm;
    in_inst.src1   = src1;
    in_inst.src2   = src2;
    in_inst.dst    = dst;

    empty = (count_q == '0);
    full  = (count_q == CNT_W'(DEPTH));
`ifdef INPUT_QUEUE_BYPASS_EN
    bypass = instv && empty && !flush;
`else
    bypass = 1'b0;
`endif
    out_valid = !empty || bypass;
    out_inst  = bypass ? in_inst : rd_data;

    // Flush empties the queue first, so the same-cycle instruction always fits.
    push = instv && (flush || !full) && !(bypass && out_ready);
    pop  = !empty && out_ready && !flush;
    overflow_d = overflow_q || (instv && full && !flush);

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = CNT_W'(push);
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  inst_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_inst),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign count    = count_q;
  assign in_ready = !full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_inst_input_queue.sv
// tb/tb_inst_input_queue.sv - randomized and directed self-checking bench against a queue model
module tb_inst_input_queue;
  import inst_input_pkg::*;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       instv = 1'b0;
  t_opcode    opcode = '0;
  t_data      imm = '0;
  t_reg_name  src1 = '0, src2 = '0, dst = '0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  t_inst      out_inst;
  logic       in_ready;
  logic       full;
  logic [2:0] count;
  logic       overflow;

  inst_input_queue #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .instv     (instv),
    .opcode    (opcode),
    .imm       (imm),
    .src1      (src1),
    .src2      (src2),
    .dst       (dst),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .in_ready  (in_ready),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  t_inst   q[$];
  t_opcode popped[$];
  bit      m_ovf = 0;
  int      passes = 0;
  int      total = 0;
  logic    st_valid;
  t_opcode st_op;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One cycle: drive at negedge, compare against the model, advance the model, wait for the edge.
  task automatic step(input logic iv, input t_opcode op, input logic fl, input logic rdy);
    t_inst ni, exp_inst;
    bit    byp, exp_valid, full0;
    @(negedge clock);
    ni.opcode = op;
    ni.imm    = t_data'($urandom);
    ni.src1   = t_reg_name'($urandom);
    ni.src2   = t_reg_name'($urandom);
    ni.dst    = t_reg_name'($urandom);
    instv = iv; opcode = ni.opcode; imm = ni.imm;
    src1 = ni.src1; src2 = ni.src2; dst = ni.dst;
    flush = fl; out_ready = rdy;
    #1;
    byp = 0;
`ifdef INPUT_QUEUE_BYPASS_EN
    byp = iv && (q.size() == 0) && !fl;
`endif
    exp_valid = (q.size() != 0) || byp;
    if (q.size() != 0) exp_inst = q[0];
    else exp_inst = ni;
    st_valid = out_valid;
    st_op    = out_inst.opcode;
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (exp_valid) chk("out_inst", 64'(out_inst), 64'(exp_inst));

    if (exp_valid && rdy && !fl) popped.push_back(exp_inst.opcode);
    if (fl) begin
      q.delete();
      if (iv) q.push_back(ni);
    end else if (byp) begin
      if (!rdy) q.push_back(ni);
    end else begin
      full0 = (q.size() == DEPTH);
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (iv) begin
        if (full0) m_ovf = 1;
        else q.push_back(ni);
      end
    end
    @(posedge clock);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_full", 64'(full), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_out_inst", 64'(out_inst), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 1; i <= 3; i++) step(1, t_opcode'(i), 0, 0);
    #1;
    chk("lit_count3", 64'(count), 3);
    chk("lit_head1", 64'(out_inst.opcode), 1);
    chk("lit_notfull", 64'(full), 0);

    step(1, 8'd4, 0, 0);
    #1;
    chk("lit_full", 64'(full), 1);
    step(1, 8'd9, 0, 1);
    #1;
    chk("lit_drop_count", 64'(count), 3);
    chk("lit_drop_ovf", 64'(overflow), 1);
    chk("lit_drop_head", 64'(out_inst.opcode), 2);

    repeat (3) step(0, 8'd0, 0, 1);
    popped.delete();
    for (int i = 0; i < 10; i++) begin
      step(1, t_opcode'(100 + i), 0, 1);
      #1;
      chk("lit_cnt_le1", 64'(count <= 3'd1), 1);
    end
    step(0, 8'd0, 0, 1);
    chk("lit_stream_len", 64'(popped.size()), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      chk("lit_stream_order", 64'(popped[i]), 64'(100 + i));

    for (int i = 0; i < 3; i++) step(1, t_opcode'(20 + i), 0, 0);
    step(1, 8'd7, 1, 0);
    #1;
    chk("lit_flush_count", 64'(count), 1);
    chk("lit_flush_head", 64'(out_inst.opcode), 7);

    step(1, 8'd30, 0, 0);
    #1;
    chk("lit_pre_rst_count", 64'(count), 2);
    chk("lit_pre_rst_ovf", 64'(overflow), 1);
    #1;
    instv = 0; flush = 0; out_ready = 0;
    reset = 1'b1;
    #1;
    chk("async_count", 64'(count), 0);
    chk("async_valid", 64'(out_valid), 0);
    chk("async_in_ready", 64'(in_ready), 1);
    chk("async_full", 64'(full), 0);
    chk("async_ovf", 64'(overflow), 0);
    chk("async_out_inst", 64'(out_inst), 0);
    q.delete();
    m_ovf = 0;
    @(negedge clock);
    reset = 1'b0;

    step(1, 8'd5, 0, 1);
    #1;
`ifdef INPUT_QUEUE_BYPASS_EN
    chk("lit_byp_valid", 64'(st_valid), 1);
    chk("lit_byp_op", 64'(st_op), 5);
    chk("lit_byp_count", 64'(count), 0);
`else
    chk("lit_nobyp_valid", 64'(st_valid), 0);
    chk("lit_nobyp_count", 64'(count), 1);
`endif

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, t_opcode'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
